mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/word_counter.sv | 23 ++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL_I  = 2'd1,
    FILL_D  = 2'd2,
    WRITE_D = 2'd3
  } arb_state_t;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_BYTES      = 2;

endpackage

// File: rtl/word_counter.sv
// Small up-counter with synchronous clear, count enable and a terminal-count
// flag. Used for both the fill issue count and the fill return count.
module word_counter #(
  parameter int W    = 3,
  parameter int LAST = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  // Count enabled events; reset and clear both return to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign tc = (count == W'(LAST));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between an I-cache (block fills) and a D-cache
// (block fills or single-word writes). Fixed D-over-I priority by default;
// defining MEM_ARB_RR_EN switches conflict resolution to round-robin using a
// last-owner bit. Fills issue WORDS reads back to back while a separate
// return counter tracks read data, so memory latency is arbitrary.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = WORDS_PER_BLOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic              i_done,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, mem_addr_q, fill_addr;
  logic [DATA_W-1:0] wdata_q, mem_wdata_q;
  logic              issued_all_q;
  logic              fill, issuing, fill_done, pick_d, prio_d;
  logic [2:0]        ic_cnt, rc_cnt;
  logic              ic_tc, rc_tc;
  logic              unused_rc;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;  // 1 = D owned memory last

  // Remember who won the most recent arbitration.
  always_ff @(posedge clk) begin
    if (rst)                                    last_d_q <= 1'b1;
    else if (state_q == IDLE && state_d != IDLE) last_d_q <= (state_d != FILL_I);
  end

  assign prio_d = ~last_d_q;
`else
  assign prio_d = 1'b1;
`endif

  assign fill      = (state_q == FILL_I) || (state_q == FILL_D);
  assign issuing   = fill && !issued_all_q;
  assign fill_done = fill && mem_data_valid && rc_tc;
  assign pick_d    = d_req && (!i_req || prio_d);
  assign fill_addr = {addr_q[ADDR_W-1:4], 4'h0}
                   + ADDR_W'(ic_cnt) * ADDR_W'(WORD_BYTES);
  assign unused_rc = ^rc_cnt;

  word_counter #(.W(3), .LAST(WORDS-1)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == IDLE),
    .en    (issuing),
    .count (ic_cnt),
    .tc    (ic_tc)
  );

  word_counter #(.W(3), .LAST(WORDS-1)) u_return_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == IDLE),
    .en    (fill && mem_data_valid),
    .count (rc_cnt),
    .tc    (rc_tc)
  );

  // State, request capture, issue-complete flag and memory command hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      issued_all_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
      if (state_q == IDLE) begin
        addr_q       <= pick_d ? d_addr : i_addr;
        wdata_q      <= d_wdata;
        issued_all_q <= 1'b0;
      end else if (issuing && ic_tc) begin
        issued_all_q <= 1'b1;
      end
    end
  end

  // Next-state arbitration and output decode.
  always_comb begin
    state_d      = state_q;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d)     state_d = d_wr ? WRITE_D : FILL_D;
        else if (i_req) state_d = FILL_I;
      end
      FILL_I: begin
        i_grant      = 1'b1;
        i_data_valid = mem_data_valid;
        i_done       = fill_done;
        if (fill_done) state_d = IDLE;
      end
      FILL_D: begin
        d_grant      = 1'b1;
        d_data_valid = mem_data_valid;
        d_done       = fill_done;
        if (fill_done) state_d = IDLE;
      end
      WRITE_D: begin
        d_grant   = 1'b1;
        d_done    = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issuing) begin
      mem_en   = 1'b1;
      mem_addr = fill_addr;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, I fill, D-over-I conflict, single
// write, reset mid-fill, stray read data in IDLE. Memory latency is 4 cycles.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done;
  logic        mem_en, mem_wr, mem_data_valid, busy;
  logic [15:0] mem_addr, mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .d_req          (d_req),
    .d_wr           (d_wr),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .i_grant        (i_grant),
    .d_grant        (d_grant),
    .i_data_valid   (i_data_valid),
    .d_data_valid   (d_data_valid),
    .i_done         (i_done),
    .d_done         (d_done),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_valid (mem_data_valid),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Called at the negedge where the request is already driven (cycle 0).
  // Cycle c is the half-period after the c-th following rising edge.
  task automatic do_fill(input bit is_d, input logic [15:0] addr);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      mem_data_valid = (c >= 5 && c <= 12);
      #1;
      chk("mem_en", mem_en, c <= 8);
      chk("mem_wr", mem_wr, 0);
      if (c <= 8) chk("fill_addr", mem_addr, base + 16'(2 * (c - 1)));
      if (c == 9) chk("addr_hold", mem_addr, base + 16'hE);
      chk("own_grant", is_d ? d_grant : i_grant, c <= 12);
      chk("oth_grant", is_d ? i_grant : d_grant, 0);
      chk("own_dv", is_d ? d_data_valid : i_data_valid, c >= 5 && c <= 12);
      chk("oth_dv", is_d ? i_data_valid : d_data_valid, 0);
      chk("own_done", is_d ? d_done : i_done, c == 12);
      chk("oth_done", is_d ? i_done : d_done, 0);
      chk("busy", busy, c <= 12);
      if (c == 12) begin
        if (is_d) d_req = 1'b0;
        else      i_req = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_data_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", {i_grant, d_grant}, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    // Single I fill, low nibble of address ignored
    i_req = 1; i_addr = 16'h1236;
    do_fill(0, 16'h1236);

    // Conflict: D fill first, then I with no lost request
    d_req = 1; d_wr = 0; d_addr = 16'h5A5F; i_req = 1; i_addr = 16'h7771;
    do_fill(1, 16'h5A5F);
    do_fill(0, 16'h7771);

    // Single-word write; read data during it is not forwarded
    d_req = 1; d_wr = 1; d_addr = 16'h0404; d_wdata = 16'hBEEF;
    @(negedge clk);
    mem_data_valid = 1;
    #1;
    chk("wr_en", mem_en, 1);
    chk("wr_wr", mem_wr, 1);
    chk("wr_addr", mem_addr, 16'h0404);
    chk("wr_wdata", mem_wdata, 16'hBEEF);
    chk("wr_done", d_done, 1);
    chk("wr_grant", d_grant, 1);
    chk("wr_dv", d_data_valid, 0);
    d_req = 0; d_wr = 0; mem_data_valid = 0;
    @(negedge clk);
    #1;
    chk("wr_en_off", mem_en, 0);
    chk("wr_wr_off", mem_wr, 0);
    chk("wr_addr_hold", mem_addr, 16'h0404);
    chk("wr_wdata_hold", mem_wdata, 16'hBEEF);
    chk("wr_done_off", d_done, 0);
    chk("wr_busy_off", busy, 0);

    // Reset after the third issued word
    i_req = 1; i_addr = 16'h2000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      chk("pre_rst_addr", mem_addr, 16'h2000 + 16'(2 * (c - 1)));
    end
    rst = 1; i_req = 0;
    @(negedge clk);
    #1;
    chk("mid_rst_grant", i_grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", mem_en, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_done", i_done, 0);
    rst = 0;
    mem_data_valid = 1;
    #1;
    chk("stray_idv", i_data_valid, 0);
    chk("stray_ddv", d_data_valid, 0);
    @(negedge clk);
    #1;
    chk("stray_idv2", i_data_valid, 0);
    chk("stray_done2", {i_done, d_done}, 0);
    mem_data_valid = 0;

    // Next fill still needs all eight returns
    i_req = 1; i_addr = 16'h3ABC;
    do_fill(0, 16'h3ABC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
